// File: rtl/timer_pkg.sv
// Shared definitions for the timer APB register block: register offsets,
// control/status bit positions and the APB handshake state encoding.
package timer_pkg;

  localparam logic [7:0] CTRL_OFF    = 8'h00;
  localparam logic [7:0] COMPARE_OFF = 8'h04;
  localparam logic [7:0] COUNT_OFF   = 8'h08;
  localparam logic [7:0] STATUS_OFF  = 8'h0C;
  localparam logic [7:0] SNAP_OFF    = 8'h10;

  localparam int CTRL_W            = 3;
  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IE_BIT       = 2;

  localparam int STATUS_PEND_BIT = 0;
  localparam int STATUS_OVF_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } apb_state_e;

endpackage

// File: rtl/timer_match_latch.sv
// Counter match edge detector with sticky PEND/OVF flags (write-1-to-clear)
// and the registered level interrupt.
module timer_match_latch (
  input  logic clk,
  input  logic rst,
  input  logic match_i,
  input  logic clr_pend_i,
  input  logic clr_ovf_i,
  input  logic ie_i,
  output logic match_edge_o,
  output logic pend_o,
  output logic ovf_o,
  output logic irq_o
);

  logic match_q;
  logic pend_q, pend_d;
  logic ovf_q, ovf_d;
  logic irq_q;

  assign match_edge_o = match_i & ~match_q;

  // A new match beats a simultaneous clear, and a match that is already being
  // cleared in the same cycle is not an overflow.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (clr_pend_i) pend_d = 1'b0;
    if (clr_ovf_i)  ovf_d  = 1'b0;
    if (match_edge_o) begin
      pend_d = 1'b1;
      if (pend_q && !clr_pend_i) ovf_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      match_q <= match_i;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      irq_q   <= pend_q & ie_i;
    end
  end

  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/timer_apb_regs.sv
// APB register front-end for the timer: CTRL/COMPARE/COUNT/STATUS registers,
// counter clear requests and interrupt. Define TIMER_SNAPSHOT_EN to add SNAPSHOT at 0x10.
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              cnt_en,
  output logic              cnt_rst,
  output logic [31:0]       cnt_compare,
  input  logic [31:0]       cnt_value,
  input  logic              cnt_match,
  output logic              irq
);

  apb_state_e        state_q;
  logic              pready_q, pslverr_q;
  logic [31:0]       prdata_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [31:0]       compare_q;
  logic              cnt_rst_q;
`ifdef TIMER_SNAPSHOT_EN
  logic [31:0]       snap_q;
`endif

  logic [ADDR_W-1:0] addr_w;
  logic [31:0]       rdata_d;
  logic              mapped;
  logic              access_ok, wr_en, rd_en;
  logic              wr_ctrl, wr_cmp, wr_status;
  logic              match_edge, pend, ovf;
  logic              unused_paddr;

  assign addr_w       = {paddr[ADDR_W-1:2], 2'b00};
  assign unused_paddr = ^paddr[1:0];

  always_comb begin
    rdata_d = '0;
    mapped  = 1'b1;
    case (addr_w)
      ADDR_W'(CTRL_OFF):    rdata_d = 32'(ctrl_q);
      ADDR_W'(COMPARE_OFF): rdata_d = compare_q;
      ADDR_W'(COUNT_OFF):   rdata_d = cnt_value;
      ADDR_W'(STATUS_OFF): begin
        rdata_d[STATUS_PEND_BIT] = pend;
        rdata_d[STATUS_OVF_BIT]  = ovf;
      end
`ifdef TIMER_SNAPSHOT_EN
      ADDR_W'(SNAP_OFF):    rdata_d = snap_q;
`endif
      default:              mapped  = 1'b0;
    endcase
  end

  // A transfer whose psel drops before the access edge is abandoned silently.
  assign access_ok = (state_q == ST_ACCESS) && psel;
  assign wr_en     = access_ok &&  pwrite && mapped;
  assign rd_en     = access_ok && !pwrite && mapped;
  assign wr_ctrl   = wr_en && (addr_w == ADDR_W'(CTRL_OFF));
  assign wr_cmp    = wr_en && (addr_w == ADDR_W'(COMPARE_OFF));
  assign wr_status = wr_en && (addr_w == ADDR_W'(STATUS_OFF));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          if (psel && penable) state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (psel) begin
            state_q   <= ST_DONE;
            pready_q  <= 1'b1;
            pslverr_q <= ~mapped;
            prdata_q  <= pwrite ? '0 : rdata_d;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      compare_q <= CMP_RESET;
      cnt_rst_q <= 1'b1;
`ifdef TIMER_SNAPSHOT_EN
      snap_q    <= '0;
`endif
    end else begin
      if (wr_ctrl) ctrl_q    <= pwdata[CTRL_W-1:0];
      if (wr_cmp)  compare_q <= pwdata;
      cnt_rst_q <= wr_cmp | (ctrl_q[CTRL_PERIODIC_BIT] & match_edge);
`ifdef TIMER_SNAPSHOT_EN
      if (rd_en && (addr_w == ADDR_W'(COUNT_OFF))) snap_q <= cnt_value;
`endif
    end
  end

  timer_match_latch u_match (
    .clk          (clk),
    .rst          (rst),
    .match_i      (cnt_match),
    .clr_pend_i   (wr_status & pwdata[STATUS_PEND_BIT]),
    .clr_ovf_i    (wr_status & pwdata[STATUS_OVF_BIT]),
    .ie_i         (ctrl_q[CTRL_IE_BIT]),
    .match_edge_o (match_edge),
    .pend_o       (pend),
    .ovf_o        (ovf),
    .irq_o        (irq)
  );

`ifndef TIMER_SNAPSHOT_EN
  logic unused_rd_en;
  assign unused_rd_en = rd_en;
`endif

  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign cnt_en      = ctrl_q[CTRL_EN_BIT];
  assign cnt_rst     = cnt_rst_q;
  assign cnt_compare = compare_q;

endmodule

// File: tb/tb_timer_apb_regs.sv
// Directed bench for timer_apb_regs: register access, match/interrupt behaviour,
// clear requests, error responses and aborted transfers.
module tb_timer_apb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        cnt_en, cnt_rst;
  logic [31:0] cnt_compare, cnt_value;
  logic        cnt_match, irq;

  int          n_cmp = 0;
  int          n_err = 0;
  int          last_lat;
  logic [31:0] rd;
  logic        err;

  always #5 clk = ~clk;

  timer_apb_regs #(.ADDR_W(5), .CMP_RESET(32'hFFFF_FFFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .cnt_en      (cnt_en),
    .cnt_rst     (cnt_rst),
    .cnt_compare (cnt_compare),
    .cnt_value   (cnt_value),
    .cnt_match   (cnt_match),
    .irq         (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full APB transfer; optionally raises cnt_match during the access cycle.
  task automatic apb(input logic [4:0] addr, input logic wr, input logic [31:0] data,
                     input bit pulse_match);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (pready) begin
        seen     = 1'b1;
        last_lat = i;
      end else if (pulse_match && i == 0) begin
        cnt_match = 1'b1;
      end
    end
    if (!seen) check("pready_timeout", {31'b0, pready}, 32'd1);
    rd  = prdata;
    err = pslverr;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; cnt_value = '0; cnt_match = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_cnt_rst", {31'b0, cnt_rst}, 32'd1);
    check("rst_pready",  {31'b0, pready},  32'd0);
    check("rst_pslverr", {31'b0, pslverr}, 32'd0);
    check("rst_prdata",  prdata,           32'd0);
    check("rst_irq",     {31'b0, irq},     32'd0);
    check("rst_cnt_en",  {31'b0, cnt_en},  32'd0);
    check("rst_compare", cnt_compare,      32'hFFFF_FFFF);
    rst = 1'b0;
    tick();
    check("post_rst_cnt_rst", {31'b0, cnt_rst}, 32'd0);
    apb(5'h00, 1'b0, '0, 1'b0);
    check("rd_ctrl_rst", rd, 32'd0);
    check("one_wait_state", last_lat, 32'd1);
    apb(5'h04, 1'b0, '0, 1'b0);
    check("rd_cmp_rst", rd, 32'hFFFF_FFFF);

    // COMPARE write pulses cnt_rst once; interrupt path with IE
    apb(5'h04, 1'b1, 32'd10, 1'b0);
    check("cmp_val",       cnt_compare,      32'd10);
    check("cmp_wr_cnt_rst", {31'b0, cnt_rst}, 32'd1);
    tick();
    check("cmp_wr_cnt_rst_end", {31'b0, cnt_rst}, 32'd0);
    apb(5'h00, 1'b1, 32'h5, 1'b0);
    check("cnt_en_set", {31'b0, cnt_en}, 32'd1);
    tick();
    cnt_match = 1'b1;
    tick();
    check("irq_after_1", {31'b0, irq}, 32'd0);
    cnt_match = 1'b0;
    tick();
    check("irq_after_2", {31'b0, irq}, 32'd1);
    apb(5'h0C, 1'b0, '0, 1'b0);
    check("status_pend", rd, 32'h1);
    apb(5'h0C, 1'b1, 32'h1, 1'b0);
    check("irq_in_done", {31'b0, irq}, 32'd1);
    tick();
    check("irq_after_w1c", {31'b0, irq}, 32'd0);

    // Overflow on a second edge, and a held match counts once
    tick(); cnt_match = 1'b1; tick(); cnt_match = 1'b0;
    tick(); cnt_match = 1'b1; tick(); cnt_match = 1'b0;
    apb(5'h0C, 1'b0, '0, 1'b0);
    check("status_ovf", rd, 32'h3);
    apb(5'h0C, 1'b1, 32'h3, 1'b0);
    tick();
    cnt_match = 1'b1;
    repeat (5) tick();
    cnt_match = 1'b0;
    apb(5'h0C, 1'b0, '0, 1'b0);
    check("held_match_once", rd, 32'h1);
    apb(5'h0C, 1'b1, 32'h1, 1'b0);

    // Periodic reload: cnt_rst one cycle after the edge, no irq with IE=0
    apb(5'h00, 1'b1, 32'h3, 1'b0);
    tick();
    cnt_match = 1'b1;
    check("per_cnt_rst_pre", {31'b0, cnt_rst}, 32'd0);
    tick();
    check("per_cnt_rst_hi", {31'b0, cnt_rst}, 32'd1);
    cnt_match = 1'b0;
    tick();
    check("per_cnt_rst_lo", {31'b0, cnt_rst}, 32'd0);
    check("irq_masked",     {31'b0, irq},     32'd0);

    // IE toggling with PEND held
    apb(5'h00, 1'b1, 32'h5, 1'b0);
    tick();
    check("irq_ie_on", {31'b0, irq}, 32'd1);
    apb(5'h00, 1'b1, 32'h1, 1'b0);
    tick();
    check("irq_ie_off", {31'b0, irq}, 32'd0);
    apb(5'h0C, 1'b0, '0, 1'b0);
    check("pend_kept", rd, 32'h1);

    // W1C coincident with a match edge: set wins, no overflow
    apb(5'h00, 1'b1, 32'h5, 1'b0);
    apb(5'h0C, 1'b1, 32'h1, 1'b1);
    cnt_match = 1'b0;
    check("w1c_race_irq", {31'b0, irq}, 32'd1);
    repeat (2) tick();
    check("w1c_race_irq_hold", {31'b0, irq}, 32'd1);
    apb(5'h0C, 1'b0, '0, 1'b0);
    check("w1c_race_status", rd, 32'h1);

    // Unmapped address and RO write
    apb(5'h14, 1'b0, '0, 1'b0);
    check("unmapped_err",  {31'b0, err}, 32'd1);
    check("unmapped_data", rd,           32'd0);
    apb(5'h08, 1'b1, 32'hDEAD, 1'b0);
    check("ro_wr_err", {31'b0, err}, 32'd0);

    // COUNT and SNAPSHOT
    cnt_value = 32'h1234;
    apb(5'h08, 1'b0, '0, 1'b0);
    check("count_rd", rd, 32'h1234);
    cnt_value = 32'h9999;
    apb(5'h10, 1'b0, '0, 1'b0);
`ifdef TIMER_SNAPSHOT_EN
    check("snap_rd",  rd,           32'h1234);
    check("snap_err", {31'b0, err}, 32'd0);
`else
    check("snap_err",  {31'b0, err}, 32'd1);
    check("snap_data", rd,           32'd0);
`endif

    // psel dropped during access: no write, no pready
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h04; pwdata = 32'h55;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
    tick();
    check("abort_pready", {31'b0, pready}, 32'd0);
    check("abort_no_wr",  cnt_compare,     32'd10);
    apb(5'h04, 1'b0, '0, 1'b0);
    check("abort_recover", rd, 32'd10);

    // rst during access aborts the transfer and restores defaults
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h04; pwdata = 32'h77;
    tick();
    penable = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("rst_abort_pready", {31'b0, pready}, 32'd0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick();
    check("rst_abort_pready2", {31'b0, pready}, 32'd0);
    check("rst_abort_cmp",     cnt_compare,     32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
